// File: rtl/seq_fixmul.sv
// Sequential signed Q-format multiplier: one radix-2 Booth step per clock, then scale and optional saturation.
// Latency WIDTH+2 cycles from the accepting edge to done; start is ignored while ready is low.
module seq_fixmul #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int PW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t             state_q;
    logic [WIDTH:0]     mcand_q;
    logic [WIDTH:0]     upper_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               qm1_q;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   result_q;
    logic               ovf_q;
    logic               ready_q;
    logic               done_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     upper_d;
    logic [WIDTH-1:0]   mplier_d;
    logic               qm1_d;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic               pos_ovf;
    logic               neg_ovf;
    logic [WIDTH-1:0]   result_d;
    logic               ovf_d;

    // The upper half carries one guard bit so a -2^(WIDTH-1) multiplicand cannot overflow mid-step.
    always_comb begin
        sum = upper_q;
        case ({mplier_q[0], qm1_q})
            2'b01:   sum = upper_q + mcand_q;
            2'b10:   sum = upper_q - mcand_q;
            default: sum = upper_q;
        endcase
        upper_d  = {sum[WIDTH], sum[WIDTH:1]};
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        qm1_d    = mplier_q[0];
    end

    always_comb begin
        prod     = $signed({upper_q, mplier_q});
        scaled   = prod >>> FRAC;
        pos_ovf  = !scaled[PW-1] && (|scaled[PW-2:WIDTH-1]);
        neg_ovf  = scaled[PW-1] && !(&scaled[PW-2:WIDTH-1]);
        ovf_d    = pos_ovf || neg_ovf;
        result_d = scaled[WIDTH-1:0];
        if (SATURATE != 0 && pos_ovf) begin
            result_d = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (SATURATE != 0 && neg_ovf) begin
            result_d = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            upper_q  <= '0;
            mplier_q <= '0;
            qm1_q    <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= {a[WIDTH-1], a};
                        mplier_q <= b;
                        upper_q  <= '0;
                        qm1_q    <= 1'b0;
                        count_q  <= CW'(WIDTH);
                        ready_q  <= 1'b0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    upper_q  <= upper_d;
                    mplier_q <= mplier_d;
                    qm1_q    <= qm1_d;
                    count_q  <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    result_q <= result_d;
                    ovf_q    <= ovf_d;
                    done_q   <= 1'b1;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;

endmodule

// File: doc/seq_fixmul.md
Name: seq_fixmul

Overview:
- Parametrised, sequential, signed two's-complement fixed-point multiplier for the PID datapath. Serves the Kp/Ki/Kd gain products.
- Replaces the fixed 16-bit combinational array multiplier. Adds configurable width, a Q-format fractional scale, saturation with an overflow flag, and a start/done handshake.
- Uses one radix-2 Booth iteration per clock, so a single adder is shared across cycles.

Parameters:
- WIDTH, 16: operand and result width in bits. Legal range is 4 to 32.
- FRAC, 8: fractional bits of the Q format. The result is the full product arithmetic-shifted right by FRAC. Legal range is 0 to WIDTH-1.
- SATURATE, 1: 1 clamps the result to the signed WIDTH range. 0 returns the low WIDTH bits of the shifted product (wrap, legacy behaviour).

Ports:
- clk  input  1  clock
- rst  input  1  reset. Synchronous, active-high, sampled on rising clk.
- start  input  1  request a multiply. Accepted only when ready=1.
- a  input  WIDTH  signed multiplicand. Sampled on the accepting edge.
- b  input  WIDTH  signed multiplier. Sampled on the accepting edge.
- ready  output  1  high in IDLE; block can accept start.
- done  output  1  one-cycle pulse; result and overflow are valid and newly updated.
- result  output  WIDTH  signed scaled product. Held until the next done.
- overflow  output  1  scaled product exceeded the signed WIDTH range. Held with result.

Behaviour:
- Reset: on rst=1 at a clock edge the block enters IDLE regardless of state, including mid-operation. The in-flight operation is discarded.
  - Values after reset: ready=1, done=0, result=0, overflow=0.
  - Internal accumulator, multiplier register and counter are cleared.
- States: IDLE, CALC, FINISH.
- IDLE:
  - ready=1.
  - start=1 at an edge latches a and b, clears the 2*WIDTH-bit accumulator and the Booth extra bit q-1, loads count=WIDTH, and moves to CALC.
  - start=0 stays in IDLE.
- CALC:
  - ready=0. start is ignored and a/b changes have no effect.
  - Each cycle performs one Booth step on {multiplier LSB, q-1}:
    - 01: add a to the upper half.
    - 10: subtract a from the upper half.
    - 00 and 11: no-op.
    - Then arithmetic-shift the accumulator:multiplier:q-1 right by 1.
  - count decrements each cycle. At count=1 the next state is FINISH, so CALC occupies exactly WIDTH cycles.
  - The upper half uses WIDTH+1 bits internally, so that -2^(WIDTH-1) operands do not overflow mid-step.
- FINISH, one cycle:
  - P = full signed 2*WIDTH product. S = P >>> FRAC (arithmetic shift, truncation toward negative infinity).
  - SATURATE=1:
    - S > 2^(WIDTH-1)-1 gives result=max positive, overflow=1.
    - S < -2^(WIDTH-1) gives result=min negative, overflow=1.
    - Otherwise result=S[WIDTH-1:0], overflow=0.
  - SATURATE=0: result=S[WIDTH-1:0]. overflow is still computed as the out-of-range flag.
  - result and overflow register at the FINISH edge, the block returns to IDLE, and done=1 for that following cycle only.
- Latency: start accepted at edge N gives done=1 and a valid result in the cycle after edge N+WIDTH+1. Throughput is one product per WIDTH+2 cycles.
- Back-to-back: in the done=1 cycle the block is in IDLE with ready=1. A start in that cycle is accepted, and the held result stays stable until the next done.
- Simultaneous rst and start: rst wins and nothing is accepted.
- Operands of 0 yield result 0, overflow 0.

Test Plan (WIDTH=16, FRAC=8, SATURATE=1 unless stated):
- Q8.8 basic: a=0x0180 (1.5), b=0x0200 (2.0) -> result=0x0300, overflow=0, done exactly 18 cycles after the accepting edge, ready low throughout.
- Signs and truncation:
  - a=0xFE80 (-1.5), b=0x0200 -> 0xFD00.
  - a=0xFFFF, b=0x0001 -> 0xFFFF (floor of -1/256).
  - a=0x0001, b=0x0001 -> 0x0000.
- Saturation:
  - a=0x6400, b=0x6400 (100*100) -> 0x7FFF, overflow=1.
  - a=0x8000, b=0x8000 -> 0x7FFF, overflow=1.
  - a=0x8000, b=0x0100 -> 0x8000, overflow=0.
- Wrap mode, SATURATE=0 and FRAC=0: a=0x0100, b=0x0101 -> result=0x0100 (low bits), overflow=1.
- Handshake:
  - start pulsed in CALC with different operands -> ignored, first result unchanged.
  - start held high during the done cycle -> second operation accepted, done again 18 cycles later.
- Reset mid-CALC: assert rst 5 cycles into an operation -> next cycle ready=1, done=0, result=0, overflow=0. No done pulse follows; a fresh start completes correctly.
